// File: rtl/bcd_display_scanner_if.sv
// Bundle for the BCD scanner: digit load side and display drive side.
// Ports: load, bcd_d0..bcd_d2 (digit source -> scanner); seg, an, err, frame_done (scanner -> display).
// master = digit source / observer, slave = scanner.
interface bcd_display_scanner_if;
  logic       load;
  logic [3:0] bcd_d0;
  logic [3:0] bcd_d1;
  logic [3:0] bcd_d2;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err;
  logic       frame_done;

  modport master (
    output load, bcd_d0, bcd_d1, bcd_d2,
    input  seg, an, err, frame_done
  );

  modport slave (
    input  load, bcd_d0, bcd_d1, bcd_d2,
    output seg, an, err, frame_done
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Latches three BCD digits and time-multiplexes them onto a 3-digit 7-segment display.
// Latency: a load is visible on seg one cycle later; each digit is held SCAN_DIV cycles.
// No backpressure: load is accepted every cycle. Ports: clk, clear (sync, active-high), bus (slave modport).
module bcd_display_scanner #(
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    clear,
  bcd_display_scanner_if.slave    bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic          presc_last;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic [3:0]    l0, l1, l2;
  logic          err_q;
  logic          frame_done_q;
  logic [6:0]    seg_c;
  logic [2:0]    an_c;
  logic          blank_tens;
  logic          blank_hund;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b1000000;
    endcase
    return s;
  endfunction

  assign presc_last = (presc == PW'(SCAN_DIV - 1));

  // Index state register, plus the prescaler, digit latches and flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      presc        <= '0;
      idx          <= 2'd0;
      l0           <= 4'd0;
      l1           <= 4'd0;
      l2           <= 4'd0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc        <= presc_last ? '0 : presc + PW'(1);
      idx          <= idx_nxt;
      // Frame ends on the edge that takes the hundreds slot back to ones.
      frame_done_q <= presc_last && (idx == 2'd2);
      if (bus.load) begin
        l0    <= bus.bcd_d0;
        l1    <= bus.bcd_d1;
        l2    <= bus.bcd_d2;
        err_q <= (bus.bcd_d0 > 4'd9) || (bus.bcd_d1 > 4'd9) || (bus.bcd_d2 > 4'd9);
      end
    end
  end

  // Next-state: advance at slot end; the illegal index 3 recovers on the next edge.
  always_comb begin
    idx_nxt = idx;
    if (idx == 2'd3)
      idx_nxt = 2'd0;
    else if (presc_last)
      idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  // A non-BCD digit is nonzero, so it naturally stops blanking below it.
  assign blank_hund = BLANK_LZ && (l2 == 4'd0);
  assign blank_tens = BLANK_LZ && (l2 == 4'd0) && (l1 == 4'd0);

  // Outputs decoded from the index and latched digits.
  always_comb begin
    an_c  = 3'b000;
    seg_c = 7'b0000000;
    case (idx)
      2'd0: begin
        an_c  = 3'b001;
        seg_c = seg_of(l0);
      end
      2'd1: begin
        an_c  = 3'b010;
        seg_c = blank_tens ? 7'b0000000 : seg_of(l1);
      end
      2'd2: begin
        an_c  = 3'b100;
        seg_c = blank_hund ? 7'b0000000 : seg_of(l2);
      end
      default: begin
        an_c  = 3'b000;
        seg_c = 7'b0000000;
      end
    endcase
  end

  assign bus.seg        = seg_c;
  assign bus.an         = an_c;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: three instances (SCAN_DIV=4 with and without blanking,
// SCAN_DIV=1 with blanking) share one stimulus stream; a time-based model checks every cycle.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_display_scanner_if if0 ();
  bcd_display_scanner_if if1 ();
  bcd_display_scanner_if if2 ();

  assign if0.load = load; assign if0.bcd_d0 = d0; assign if0.bcd_d1 = d1; assign if0.bcd_d2 = d2;
  assign if1.load = load; assign if1.bcd_d0 = d0; assign if1.bcd_d1 = d1; assign if1.bcd_d2 = d2;
  assign if2.load = load; assign if2.bcd_d0 = d0; assign if2.bcd_d1 = d1; assign if2.bcd_d2 = d2;

  bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u0 (.clk(clk), .clear(clear), .bus(if0));
  bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u1 (.clk(clk), .clear(clear), .bus(if1));
  bcd_display_scanner #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) u2 (.clk(clk), .clear(clear), .bus(if2));

  // ---------------- model ----------------
  logic [6:0] seg_tbl [10];
  logic [3:0] ml [3];
  logic       merr = 1'b0;
  int         t = 0;        // edges since the last clear
  bit         seen = 1'b0;  // a clear has been observed

  initial begin
    seg_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    ml = '{4'd0, 4'd0, 4'd0};
  end

  always @(posedge clk) begin
    if (clear) begin
      t    = 0;
      ml   = '{4'd0, 4'd0, 4'd0};
      merr = 1'b0;
      seen = 1'b1;
    end else if (seen) begin
      t = t + 1;
      if (load) begin
        ml[0] = d0; ml[1] = d1; ml[2] = d2;
        merr  = (d0 > 9) || (d1 > 9) || (d2 > 9);
      end
    end
  end

  // Digit shown in slot pos: blank when blanking is on, pos is not the ones
  // digit, and this digit and every digit above it are zero.
  function automatic logic [6:0] exp_seg(int pos, bit lz);
    logic [6:0] s;
    bit         blank;
    s     = (ml[pos] <= 4'd9) ? seg_tbl[ml[pos]] : 7'b1000000;
    blank = lz && (pos > 0);
    for (int j = pos; j < 3; j++)
      if (ml[j] != 4'd0) blank = 1'b0;
    return blank ? 7'b0000000 : s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic check_inst(input string nm, input int sd, input bit lz,
                            input logic [6:0] seg, input logic [2:0] an,
                            input logic err, input logic fd);
    int pos;
    pos = (t / sd) % 3;
    chk({nm, ".an"},  32'(an),  32'(3'b001 << pos));
    chk({nm, ".seg"}, 32'(seg), 32'(exp_seg(pos, lz)));
    chk({nm, ".err"}, 32'(err), 32'(merr));
    chk({nm, ".frame_done"}, 32'(fd), 32'((t > 0) && (t % (3 * sd) == 0)));
  endtask

  always @(negedge clk) begin
    if (seen) begin
      check_inst("u0", 4, 1'b1, if0.seg, if0.an, if0.err, if0.frame_done);
      check_inst("u1", 4, 1'b0, if1.seg, if1.an, if1.err, if1.frame_done);
      check_inst("u2", 1, 1'b1, if2.seg, if2.an, if2.err, if2.frame_done);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] te, input logic [3:0] o);
    d2 = h; d1 = te; d0 = o; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // Waits (bounded) until u0 drives the requested digit enable.
  task automatic wait_an(input logic [2:0] target);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.an == target) return;
    end
    chk("wait_an timeout", 32'(if0.an), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    clear = 1'b1;
    tick(2);
    clear = 1'b0;
    @(negedge clk);
    chk("reset an",  32'(if0.an),  32'(3'b001));
    chk("reset seg", 32'(if0.seg), 32'(7'b0111111));
    chk("reset err", 32'(if0.err), 32'(1'b0));
    chk("reset fd",  32'(if0.frame_done), 32'(1'b0));

    // Idle scanning across several frames.
    tick(30);

    // 179
    do_load(4'd1, 4'd7, 4'd9);
    @(negedge clk);
    chk("179 err", 32'(if0.err), 32'(1'b0));
    wait_an(3'b001); chk("179 ones", 32'(if0.seg), 32'(7'b1101111));
    wait_an(3'b010); chk("179 tens", 32'(if0.seg), 32'(7'b0000111));
    wait_an(3'b100); chk("179 hund", 32'(if0.seg), 32'(7'b0000110));

    // 17: hundreds blanked only where blanking is enabled.
    do_load(4'd0, 4'd1, 4'd7);
    wait_an(3'b100);
    chk("17 hund blank", 32'(if0.seg), 32'(7'b0000000));
    chk("17 hund nolz",  32'(if1.seg), 32'(7'b0111111));
    wait_an(3'b001); chk("17 ones", 32'(if0.seg), 32'(7'b0000111));
    wait_an(3'b010); chk("17 tens", 32'(if0.seg), 32'(7'b0000110));

    // 170 then 000 loaded mid-slot.
    do_load(4'd1, 4'd7, 4'd0);
    wait_an(3'b010);
    tick(1);
    do_load(4'd0, 4'd0, 4'd0);
    wait_an(3'b100); chk("000 hund", 32'(if0.seg), 32'(7'b0000000));
    wait_an(3'b001); chk("000 ones", 32'(if0.seg), 32'(7'b0111111));
    wait_an(3'b010); chk("000 tens", 32'(if0.seg), 32'(7'b0000000));

    // Non-BCD tens digit.
    do_load(4'd0, 4'd12, 4'd3);
    @(negedge clk);
    chk("nonbcd err", 32'(if0.err), 32'(1'b1));
    wait_an(3'b010); chk("nonbcd tens", 32'(if0.seg), 32'(7'b1000000));
    wait_an(3'b100); chk("nonbcd hund", 32'(if0.seg), 32'(7'b0000000));
    do_load(4'd0, 4'd0, 4'd5);
    @(negedge clk);
    chk("005 err", 32'(if0.err), 32'(1'b0));

    // Clear together with load during the tens slot.
    do_load(4'd0, 4'd12, 4'd3);
    wait_an(3'b010);
    d2 = 4'd9; d1 = 4'd9; d0 = 4'd9;
    clear = 1'b1; load = 1'b1;
    tick(1);
    clear = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("clr an",  32'(if0.an),  32'(3'b001));
    chk("clr seg", 32'(if0.seg), 32'(7'b0111111));
    chk("clr err", 32'(if0.err), 32'(1'b0));
    chk("clr fd",  32'(if0.frame_done), 32'(1'b0));

    tick(30);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
